muldiv_issue_ctrl: RTL

Issue and writeback scheduler for the multi-cycle multiplier and divider launched from the decode stage. It accepts M-extension instructions from decode and pulses start to the selected unit. It tracks each unit's destination register, raising a decode hold on structural, RAW and WAW conflicts. It arbitrates the single shared register-file writeback slot between the two units and the main pipeline.

---
 rtl/muldiv_issue_ctrl_if.sv | 20 ++
 rtl/muldiv_issue_ctrl.sv | 73 +++++++
 2 files changed

// File: rtl/muldiv_issue_ctrl_if.sv
// muldiv_issue_ctrl_if: decode, functional-unit and writeback signals of the mul/div issue scheduler.
interface muldiv_issue_ctrl_if #(parameter int XLEN = 32);
    logic stall, id_mul, id_div, id_flush, kill;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic mul_valid, div_valid, wb_port_busy;
    logic [XLEN-1:0] mul_res, div_res;
    logic mul_start, div_start, mul_ready, div_ready, hz_md, wb_valid;
    logic [4:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    modport master (
        output stall, id_mul, id_div, id_flush, kill, id_rd, id_rs1, id_rs2,
               mul_valid, div_valid, wb_port_busy, mul_res, div_res,
        input  mul_start, div_start, mul_ready, div_ready, hz_md, wb_valid, wb_rd, wb_data
    );
    modport slave (
        input  stall, id_mul, id_div, id_flush, kill, id_rd, id_rs1, id_rs2,
               mul_valid, div_valid, wb_port_busy, mul_res, div_res,
        output mul_start, div_start, mul_ready, div_ready, hz_md, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: issues M-extension ops to mul/div units, raises decode holds, arbitrates the shared writeback slot.
module muldiv_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter bit RR_INIT = 1'b0
) (
    input logic clk,
    input logic Rst,
    muldiv_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t mul_st, div_st;
    logic [4:0] mul_rd, div_rd;
    logic [XLEN-1:0] mul_q, div_q;
    logic rr;
    logic mul_pend, div_pend, raw, hz, mul_go, div_go, mul_el, div_el, mul_win, div_win;
    always_comb begin
        mul_pend = mul_st != IDLE && mul_rd != 5'd0;
        div_pend = div_st != IDLE && div_rd != 5'd0;
        raw = (mul_pend && (mul_rd == bus.id_rs1 || mul_rd == bus.id_rs2 || mul_rd == bus.id_rd)) ||
              (div_pend && (div_rd == bus.id_rs1 || div_rd == bus.id_rs2 || div_rd == bus.id_rd));
        hz = !Rst && !bus.id_flush &&
             ((bus.id_mul && mul_st != IDLE) || (bus.id_div && div_st != IDLE) || raw);
        mul_go = !Rst && bus.id_mul && mul_st == IDLE && !hz && !bus.stall && !bus.id_flush && !bus.kill;
        div_go = !Rst && bus.id_div && div_st == IDLE && !hz && !bus.stall && !bus.id_flush && !bus.kill;
        // DONE is only reachable with a nonzero rd, so DONE alone marks eligibility
        mul_el = !Rst && !bus.kill && !bus.wb_port_busy && mul_st == DONE;
        div_el = !Rst && !bus.kill && !bus.wb_port_busy && div_st == DONE;
        mul_win = mul_el && (!div_el || !rr);
        div_win = div_el && (!mul_el || rr);
    end
    assign bus.mul_start = mul_go;
    assign bus.div_start = div_go;
    assign bus.mul_ready = !Rst && mul_st == IDLE;
    assign bus.div_ready = !Rst && div_st == IDLE;
    assign bus.hz_md     = hz;
    assign bus.wb_valid  = mul_win || div_win;
    assign bus.wb_rd     = mul_win ? mul_rd : div_win ? div_rd : 5'd0;
    assign bus.wb_data   = mul_win ? mul_q : div_win ? div_q : '0;
    always_ff @(posedge clk) begin
        if (Rst) begin
            mul_st <= IDLE;
            div_st <= IDLE;
            mul_rd <= 5'd0;
            div_rd <= 5'd0;
            mul_q  <= '0;
            div_q  <= '0;
            rr     <= RR_INIT;
        end else if (bus.kill) begin
            mul_st <= IDLE;
            div_st <= IDLE;
        end else begin
            if (mul_go) begin
                mul_st <= BUSY;
                mul_rd <= bus.id_rd;
            end else if (mul_st == BUSY && bus.mul_valid) begin
                mul_st <= mul_rd == 5'd0 ? IDLE : DONE;
                mul_q  <= bus.mul_res;
            end else if (mul_win) begin
                mul_st <= IDLE;
            end
            if (div_go) begin
                div_st <= BUSY;
                div_rd <= bus.id_rd;
            end else if (div_st == BUSY && bus.div_valid) begin
                div_st <= div_rd == 5'd0 ? IDLE : DONE;
                div_q  <= bus.div_res;
            end else if (div_win) begin
                div_st <= IDLE;
            end
            if (mul_el && div_el) rr <= ~rr;
        end
    end
endmodule
